// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stream interface between a producer, the skid register and a consumer.
// slave modport: the skid register. master modport: the environment around it.
interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic 2-entry pipeline register (skid buffer) with valid/ready flow control.
// in_ready, out_valid and out_data all come straight from flops, so neither handshake
// direction has a combinational path through the block.
// Optional: define SKID_XFER_CNT_EN to add a 16-bit wrapping count of output handshakes.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_skid_reg_if.slave      bus
`ifdef SKID_XFER_CNT_EN
    ,
    output logic [15:0]         xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_d;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_deliver;

    assign w_accept      = bus.in_valid & r_in_ready;
    assign w_deliver     = r_out_valid & bus.out_ready;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;

    // Next-state and storage steering; flush voids any concurrent handshake.
    always_comb begin
        w_state_d = r_state;
        w_main_d  = r_main;
        w_skid_d  = r_skid;
        if (flush) begin
            w_state_d = StEmpty;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_main_d  = bus.in_data;
                        w_state_d = StOne;
                    end
                end
                StOne: begin
                    if (w_accept && w_deliver) begin
                        w_main_d = bus.in_data;
                    end else if (w_accept) begin
                        w_skid_d  = bus.in_data;
                        w_state_d = StTwo;
                    end else if (w_deliver) begin
                        w_state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (w_deliver) begin
                        w_main_d  = r_skid;
                        w_state_d = StOne;
                    end
                end
                default: begin
                    w_state_d = StEmpty;
                end
            endcase
        end
    end

    // State, storage and registered handshake outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StEmpty;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_main      <= w_main_d;
            r_skid      <= w_skid_d;
            r_out_valid <= (w_state_d != StEmpty);
            r_in_ready  <= (w_state_d != StTwo);
        end
    end

`ifdef SKID_XFER_CNT_EN
    logic [15:0] r_xfer_cnt;

    // Delivery counter; survives flush, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (w_deliver && !flush) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
